bcd_chain_ctrl: RTL and testbench

BCD_CHAIN_CTRL -- requirements
Module: bcd_chain_ctrl

---
 rtl/bcd_chain_ctrl_pkg.sv | 25 ++
 rtl/bcd_digit_cell.sv | 52 +++++
 rtl/bcd_chain_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bcd_chain_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_chain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_chain_ctrl_pkg
// Brief   : Shared state encoding, BCD constants and helpers for the counter.
// Revision: 1.0 - initial release
// ============================================================================
package bcd_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int         DIGITS_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  // Out-of-range nibbles saturate to the largest legal BCD digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_cell
// Brief   : One registered BCD digit with parallel load, up/down step and
//           zero/nine flags for building carry/borrow chains.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_cell
  import bcd_chain_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] digit,
  output logic       is_zero,
  output logic       is_nine
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Load wins over step so a clear/shift never races a count.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (step) begin
      if (dir) begin
        digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == 4'd0);
  assign is_nine = (digit_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/bcd_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bcd_chain_ctrl
// Brief   : Cascaded up/down BCD counter with serial digit load, wrap/stop at
//           terminal count and a registered terminal-count pulse.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_chain_ctrl
  import bcd_chain_ctrl_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  up_down,
  input  logic                  wrap_en,
  input  logic                  tick,
  input  logic                  ld_valid,
  input  logic [3:0]            ld_data,
  output logic                  ld_ready,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  tc,
  output logic [1:0]            state_out
);

  localparam int             CW   = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tc_q, tc_d;

  logic [DIGITS-1:0] w_zero;
  logic [DIGITS-1:0] w_nine;
  logic [DIGITS-1:0] w_flag;
  logic [DIGITS-1:0] w_chain;
  logic              w_terminal;
  logic              w_shift;
  logic              w_clear;
  logic              w_run_step;

  // Digit i may step only when every lower digit sits at its rollover value.
  always_comb begin
    w_flag     = up_down ? w_nine : w_zero;
    w_chain    = '0;
    w_chain[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      w_chain[i] = w_chain[i-1] & w_flag[i-1];
    end
    w_terminal = w_chain[DIGITS-1] & w_flag[DIGITS-1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tc_d       = 1'b0;
    w_shift    = 1'b0;
    w_clear    = 1'b0;
    w_run_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (clear) begin
            w_clear = 1'b1;
          end else if (ld_valid) begin
            w_shift = 1'b1;
          end else if (start) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (clear) begin
          w_clear = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ld_valid) begin
          w_shift = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (w_terminal) begin
            tc_d = 1'b1;
            if (wrap_en) begin
              w_run_step = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            w_run_step = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (clear) begin
          w_clear = 1'b1;
          state_d = ST_IDLE;
        end else if (ld_valid) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The final nibble of a load sequence returns the controller to IDLE.
    if (w_shift) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
      logic [3:0] w_shift_val;
      logic [3:0] w_load_val;

      if (i == DIGITS - 1) begin : g_top
        assign w_shift_val = clamp_bcd(ld_data);
      end else begin : g_inner
        assign w_shift_val = digits_out[4*(i+1) +: 4];
      end

      assign w_load_val = w_clear ? 4'd0 : w_shift_val;

      bcd_digit_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .load     (w_shift | w_clear),
        .load_val (w_load_val),
        .step     (w_run_step & w_chain[i]),
        .dir      (up_down),
        .digit    (digits_out[4*i +: 4]),
        .is_zero  (w_zero[i]),
        .is_nine  (w_nine[i])
      );
    end
  endgenerate

  assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign tc        = tc_q;
  assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_chain_ctrl
// Brief   : Self-checking bench: integer-value reference model compared every
//           cycle, plus directed scenarios with literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_chain_ctrl;

  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;
  localparam int TOPW   = 1000;

  logic                clk = 1'b0;
  logic                reset, start, stop, clear, up_down, wrap_en, tick, ld_valid;
  logic [3:0]          ld_data;
  logic                ld_ready;
  logic [4*DIGITS-1:0] digits_out;
  logic                tc;
  logic [1:0]          state_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: the counter value as a plain integer.
  int m_val, m_state, m_cnt;
  bit m_tc;

  always #5 clk = ~clk;

  bcd_chain_ctrl #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .up_down    (up_down),
    .wrap_en    (wrap_en),
    .tick       (tick),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .digits_out (digits_out),
    .tc         (tc),
    .state_out  (state_out)
  );

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_accept();
    int d;
    d = (ld_data > 4'd9) ? 9 : int'(ld_data);
    m_val = m_val / 10 + d * TOPW;
    m_cnt++;
    if (m_cnt == DIGITS) begin
      m_cnt   = 0;
      m_state = 0;
    end else begin
      m_state = 1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_val = 0; m_state = 0; m_cnt = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      case (m_state)
        0: if (!stop) begin
             if (clear) m_val = 0;
             else if (ld_valid) m_accept();
             else if (start) m_state = 2;
           end
        1: if (stop) begin m_state = 0; m_cnt = 0; end
           else if (clear) begin m_val = 0; m_cnt = 0; m_state = 0; end
           else if (ld_valid) m_accept();
        2: if (stop) m_state = 0;
           else if (tick) begin
             if ((up_down && m_val == MAXV) || (!up_down && m_val == 0)) begin
               m_tc = 1;
               if (wrap_en) m_val = up_down ? 0 : MAXV;
               else m_state = 3;
             end else begin
               m_val = up_down ? m_val + 1 : m_val - 1;
             end
           end
        default: if (stop) m_state = 0;
                 else if (clear) begin m_val = 0; m_state = 0; end
                 else if (ld_valid) begin m_state = 1; m_cnt = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_digits",   32'(digits_out), 32'(to_bcd(m_val)));
      chk("cmp_tc",       32'(tc),         32'(m_tc));
      chk("cmp_state",    32'(state_out),  32'(m_state));
      chk("cmp_ld_ready", 32'(ld_ready),   32'(m_state <= 1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // nibs holds the desired final digits; digit 0 is sent first.
  task automatic load4(input logic [15:0] nibs);
    ld_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld_data = nibs[4*i +: 4];
      chk("load_ready", 32'(ld_ready), 32'd1);
      cyc();
    end
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; clear = 0; up_down = 1; wrap_en = 0;
    tick = 0; ld_valid = 0; ld_data = 4'd0;
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_state",  32'(state_out),  32'd0);
    chk("rst_ready",  32'(ld_ready),   32'd1);
    chk("rst_tc",     32'(tc),         32'd0);

    load4(16'h0123);
    chk("load_digits", 32'(digits_out), 32'h0123);
    chk("load_state",  32'(state_out),  32'd0);

    do_tick();
    chk("idle_tick", 32'(digits_out), 32'h0123);

    load4(16'h0999);
    up_down = 1'b1;
    pulse_start();
    chk("start_run", 32'(state_out), 32'd2);
    do_tick();
    chk("carry_digits", 32'(digits_out), 32'h1000);
    chk("carry_tc",     32'(tc),         32'd0);
    pulse_stop();

    load4(16'h9999);
    wrap_en = 1'b0;
    pulse_start();
    do_tick();
    chk("term_tc",     32'(tc),         32'd1);
    chk("term_digits", 32'(digits_out), 32'h9999);
    chk("term_state",  32'(state_out),  32'd3);
    cyc();
    chk("term_tc_once", 32'(tc), 32'd0);
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    chk("done_hold", 32'(digits_out), 32'h9999);
    chk("done_tc",   32'(tc),         32'd0);

    clear = 1'b1; cyc(); clear = 1'b0;
    chk("done_clear", 32'(digits_out), 32'h0);
    chk("done_idle",  32'(state_out),  32'd0);
    up_down = 1'b0; wrap_en = 1'b1;
    pulse_start();
    do_tick();
    chk("wrapdn_digits", 32'(digits_out), 32'h9999);
    chk("wrapdn_tc",     32'(tc),         32'd1);
    chk("wrapdn_state",  32'(state_out),  32'd2);
    up_down = 1'b1;
    do_tick();
    chk("wrapup_digits", 32'(digits_out), 32'h0000);
    chk("wrapup_tc",     32'(tc),         32'd1);
    pulse_stop();

    load4(16'h1000);
    up_down = 1'b0;
    pulse_start();
    do_tick();
    chk("borrow_digits", 32'(digits_out), 32'h0999);
    pulse_stop();

    load4(16'h000C);
    chk("clamp_digits", 32'(digits_out), 32'h0009);
    pulse_start();
    stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
    chk("stoptick_digits", 32'(digits_out), 32'h0009);
    chk("stoptick_state",  32'(state_out),  32'd0);

    ld_valid = 1'b1;
    ld_data = 4'd5; cyc();
    ld_data = 4'd6; cyc();
    ld_valid = 1'b0;
    chk("part_state", 32'(state_out), 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("ldrst_digits", 32'(digits_out), 32'h0);
    chk("ldrst_state",  32'(state_out),  32'd0);
    load4(16'h4321);
    chk("reload_digits", 32'(digits_out), 32'h4321);
    chk("reload_state",  32'(state_out),  32'd0);

    load4(16'h9999);
    up_down = 1'b1; wrap_en = 1'b1;
    pulse_start();
    tick = 1'b1; reset = 1'b1; cyc(); tick = 1'b0; reset = 1'b0;
    chk("runrst_tc",     32'(tc),         32'd0);
    chk("runrst_digits", 32'(digits_out), 32'h0);
    cyc();
    chk("runrst_tc2",   32'(tc),        32'd0);
    chk("runrst_state", 32'(state_out), 32'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
